// File: rtl/bsg_activation_pkg.sv
// bsg_activation_pkg: shared fixed-point format constants for activation blocks
package bsg_activation_pkg;
  localparam int frac_in_bits  = 16;
  localparam int frac_out_bits = 14;
  localparam int one_q14       = 16384;
  localparam int neg_one_q14   = -16384;
endpackage

// File: rtl/bsg_tanh_quantize_fifo.sv
// bsg_tanh_quantize_fifo: els_p-entry FIFO holding {quantized, sat} results
//   clk_i/reset_n_i : clock, synchronous active-low reset
//   data_i/enq_i    : write port (ignored when full)
//   data_o/deq_i    : head entry (zero when empty) and pop (ignored when empty)
//   full_o/empty_o  : occupancy flags
module bsg_tanh_quantize_fifo #(
  parameter int width_p = 17,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               enq_i,
  input  logic               deq_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);
  localparam int pw = $clog2(els_p);
  localparam int cw = $clog2(els_p + 1);
  logic [width_p-1:0] r_mem [els_p];
  logic [pw-1:0] r_rptr, r_wptr;
  logic [cw-1:0] r_cnt;
  logic w_enq, w_deq;
  assign full_o  = r_cnt == cw'(els_p);
  assign empty_o = r_cnt == '0;
  assign w_enq   = enq_i && !full_o;
  assign w_deq   = deq_i && !empty_o;
  assign data_o  = empty_o ? '0 : r_mem[r_rptr];
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_enq) r_wptr <= (r_wptr == pw'(els_p - 1)) ? '0 : r_wptr + 1'b1;
      if (w_deq) r_rptr <= (r_rptr == pw'(els_p - 1)) ? '0 : r_rptr + 1'b1;
      r_cnt <= r_cnt + cw'(w_enq) - cw'(w_deq);
    end
  end
  // storage needs no reset: empty entries are masked at data_o
  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr] <= data_i;
  end
endmodule

// File: rtl/bsg_tanh_quantize.sv
// bsg_tanh_quantize: round Q(n).16 tanh result to Q2.14, clamp to [-1,+1], buffer
//   clk_i/reset_n_i      : clock, synchronous active-low reset
//   data_i/v_i/ready_o   : input handshake from the divider
//   data_o/sat_o/v_o/yumi_i : buffered result to the consumer
//   sat_count_o          : saturating count of clamped accepts
//   BSG_TANH_QUANTIZE_SAT_CNT_EN enables the counter; otherwise it reads 0
module bsg_tanh_quantize
  import bsg_activation_pkg::*;
#(
  parameter int in_width_p  = 32,
  parameter int out_width_p = 16,
  parameter int els_p       = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [in_width_p-1:0]  data_i,
  input  logic                   v_i,
  output logic                   ready_o,
  output logic [out_width_p-1:0] data_o,
  output logic                   sat_o,
  output logic                   v_o,
  input  logic                   yumi_i,
  output logic [15:0]            sat_count_o
);
  localparam int shift_lp = frac_in_bits - frac_out_bits;
  localparam logic signed [in_width_p:0] half_lp = (in_width_p+1)'(1 << (shift_lp - 1));
  localparam logic signed [in_width_p:0] hi_lp   = (in_width_p+1)'(one_q14);
  localparam logic signed [in_width_p:0] lo_lp   = (in_width_p+1)'(neg_one_q14);
  logic signed [in_width_p:0] w_ext, w_rnd;
  logic [out_width_p-1:0] w_q;
  logic w_hi, w_lo, w_sat, w_full, w_empty, w_enq;
  // one guard bit so the rounding add cannot overflow at max positive input
  assign w_ext = $signed({data_i[in_width_p-1], data_i}) + half_lp;
  assign w_rnd = w_ext >>> shift_lp;
  assign w_hi  = w_rnd > hi_lp;
  assign w_lo  = w_rnd < lo_lp;
  assign w_sat = w_hi || w_lo;
  assign w_q   = w_hi ? out_width_p'(one_q14) : w_lo ? out_width_p'(neg_one_q14) : w_rnd[out_width_p-1:0];
  assign ready_o = !w_full;
  assign v_o     = !w_empty;
  assign w_enq   = v_i && !w_full;
  bsg_tanh_quantize_fifo #(
    .width_p(out_width_p + 1),
    .els_p  (els_p)
  ) u_fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .data_i   ({w_q, w_sat}),
    .enq_i    (w_enq),
    .deq_i    (yumi_i && !w_empty),
    .data_o   ({data_o, sat_o}),
    .full_o   (w_full),
    .empty_o  (w_empty)
  );
`ifdef BSG_TANH_QUANTIZE_SAT_CNT_EN
  logic [15:0] r_sat_cnt;
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) r_sat_cnt <= '0;
    else if (w_enq && w_sat && r_sat_cnt != 16'hFFFF) r_sat_cnt <= r_sat_cnt + 16'd1;
  end
  assign sat_count_o = r_sat_cnt;
`else
  assign sat_count_o = '0;
`endif
endmodule

// File: tb/tb_bsg_tanh_quantize.sv
// tb_bsg_tanh_quantize: directed and random checks against a queue-based reference model
module tb_bsg_tanh_quantize;
  logic clk = 0;
  logic reset_n;
  logic [31:0] data_i;
  logic v_i, yumi_i, ready_o, sat_o, v_o;
  logic [15:0] data_o, sat_count_o;
  int checks = 0, errors = 0;
  logic [16:0] q[$];
  int model_cnt = 0;
  always #5 clk = ~clk;
  bsg_tanh_quantize dut (
    .clk_i(clk), .reset_n_i(reset_n), .data_i(data_i), .v_i(v_i), .ready_o(ready_o),
    .data_o(data_o), .sat_o(sat_o), .v_o(v_o), .yumi_i(yumi_i), .sat_count_o(sat_count_o)
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask
  // real-number view: value/4 rounded half-up, then limited to +-1.0
  function automatic logic [16:0] ref_q(input logic [31:0] d);
    longint v, r;
    v = longint'($signed(d));
    r = (v + 2) >>> 2;
    if (r > 16384) return {16'h4000, 1'b1};
    if (r < -16384) return {16'hC000, 1'b1};
    return {r[15:0], 1'b0};
  endfunction
  function automatic logic [15:0] exp_cnt();
`ifdef BSG_TANH_QUANTIZE_SAT_CNT_EN
    return 16'(model_cnt);
`else
    return 16'h0;
`endif
  endfunction
  task automatic check_outs();
    chk("v_o", 32'(v_o), 32'(q.size() > 0));
    chk("ready_o", 32'(ready_o), 32'(q.size() < 2));
    chk("data_o", 32'(data_o), q.size() > 0 ? 32'(q[0][16:1]) : 32'h0);
    chk("sat_o", 32'(sat_o), q.size() > 0 ? 32'(q[0][0]) : 32'h0);
    chk("sat_count_o", 32'(sat_count_o), 32'(exp_cnt()));
  endtask
  task automatic step(input logic v, input logic [31:0] d, input logic y);
    logic acc, deq;
    logic [16:0] e;
    v_i = v; data_i = d; yumi_i = y;
    @(negedge clk);
    check_outs();
    acc = v && q.size() < 2;
    deq = y && q.size() > 0;
    e = ref_q(d);
    @(posedge clk); #1;
    if (deq) void'(q.pop_front());
    if (acc) q.push_back(e);
    if (acc && e[0] && model_cnt < 65535) model_cnt++;
  endtask
  task automatic do_reset();
    reset_n = 0; v_i = 0; yumi_i = 0; data_i = 0;
    @(posedge clk); #1;
    reset_n = 1;
    q.delete();
    model_cnt = 0;
  endtask
  initial begin
    logic [31:0] d;
    reset_n = 0; v_i = 0; yumi_i = 0; data_i = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    q.delete();
    @(negedge clk);
    chk("rst_v_o", 32'(v_o), 32'h0);
    chk("rst_ready", 32'(ready_o), 32'h1);
    chk("rst_data", 32'(data_o), 32'h0);
    chk("rst_cnt", 32'(sat_count_o), 32'h0);
    @(posedge clk); #1;
    // 0.5 -> 0x2000, visible one cycle after accept
    step(1, 32'h00008000, 0);
    chk("half_v", 32'(v_o), 32'h1);
    chk("half_data", 32'(data_o), 32'h2000);
    chk("half_sat", 32'(sat_o), 32'h0);
    step(1, 32'h00018000, 1);
    chk("pos_data", 32'(data_o), 32'h4000);
    chk("pos_sat", 32'(sat_o), 32'h1);
    step(1, 32'hFFFE0000, 1);
    chk("neg_data", 32'(data_o), 32'hC000);
    chk("neg_sat", 32'(sat_o), 32'h1);
    step(0, 0, 1);
    step(0, 0, 0);
    foreach (d[i]) ;
    step(1, 32'h00000002, 0); step(0, 0, 1);
    step(1, 32'h00000001, 0); step(0, 0, 1);
    step(1, 32'hFFFFFFFF, 0); step(0, 0, 1);
    step(1, 32'h00010001, 0);
    chk("edge_data", 32'(data_o), 32'h4000);
    chk("edge_sat", 32'(sat_o), 32'h0);
    step(0, 0, 1);
    // backpressure: A,B fill the FIFO, C waits and is never bypassed in
    do_reset();
    step(1, 32'h00001000, 0);
    step(1, 32'h00002000, 0);
    chk("bp_ready", 32'(ready_o), 32'h0);
    step(1, 32'h00003000, 0);
    step(1, 32'h00003000, 1);
    chk("bp_B", 32'(data_o), 32'h0800);
    step(1, 32'h00003000, 1);
    chk("bp_C", 32'(data_o), 32'h0C00);
    step(0, 0, 1);
    step(0, 0, 0);
    // reset with two buffered entries
    step(1, 32'h00020000, 0);
    step(1, 32'h00004000, 0);
    do_reset();
    @(negedge clk);
    chk("mrst_v_o", 32'(v_o), 32'h0);
    chk("mrst_ready", 32'(ready_o), 32'h1);
    chk("mrst_cnt", 32'(sat_count_o), 32'h0);
    @(posedge clk); #1;
    repeat (3) step(0, 0, 1);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 2))
        0: d = $urandom;
        1: d = 32'($signed($urandom_range(0, 20'h3FFFF)) - 32'sh1FFFF);
        default: d = 32'($signed($urandom_range(0, 7)) - 32'sh3) + ($urandom_range(0, 1) ? 32'h00010000 : 32'hFFFF0000);
      endcase
      step(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)));
    end
    // counter saturation: more than 65535 clamped accepts
    do_reset();
    for (int i = 0; i < 65540; i++) step(1, 32'h00020000, 1);
    step(0, 0, 1);
`ifdef BSG_TANH_QUANTIZE_SAT_CNT_EN
    chk("cnt_sat", 32'(sat_count_o), 32'h0000FFFF);
`else
    chk("cnt_off", 32'(sat_count_o), 32'h0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
